// File: rtl/quad_enc_multi_if.sv
// quad_enc_multi_if: encoder pins, per-channel control pulses and decoded outputs of quad_enc_multi
interface quad_enc_multi_if #(
  parameter int NUM_CH  = 4,
  parameter int COUNT_W = 13,
  parameter int VEL_W   = 16
);
  logic [NUM_CH-1:0]         enc_a, enc_b, enc_i;
  logic [NUM_CH-1:0]         home, arm_index, err_clr;
  logic [NUM_CH*COUNT_W-1:0] count;
  logic [NUM_CH-1:0]         index_armed, index_found, err;
  logic [NUM_CH*VEL_W-1:0]   vel;
  logic                      vel_valid;
  modport master (
    output enc_a, enc_b, enc_i, home, arm_index, err_clr,
    input  count, index_armed, index_found, err, vel, vel_valid
  );
  modport slave (
    input  enc_a, enc_b, enc_i, home, arm_index, err_clr,
    output count, index_armed, index_found, err, vel, vel_valid
  );
endinterface

// File: rtl/quad_enc_multi.sv
// quad_enc_multi: multi-channel 4X quadrature decoder with filtering, modulo count, index homing, error flags
// Define QENC_VELOCITY_EN to add the windowed per-channel velocity accumulators.
module quad_enc_multi #(
  parameter int NUM_CH         = 4,
  parameter int COUNTS_PER_REV = 8192,
  parameter int COUNT_W        = 13,
  parameter int FILTER_LEN     = 4,
  parameter int VEL_PERIOD     = 100000,
  parameter int VEL_W          = 16
) (
  input logic             sclk,
  input logic             rstn,
  quad_enc_multi_if.slave bus
);
  localparam int NS = 3 * NUM_CH;
  localparam int RW = $clog2(FILTER_LEN + 1);
  localparam logic [COUNT_W-1:0] CMAX = COUNT_W'(COUNTS_PER_REV - 1);
  if (FILTER_LEN < 1 || 2**COUNT_W < COUNTS_PER_REV || VEL_PERIOD < 1) begin : g_bad_cfg
    $error("quad_enc_multi: inconsistent parameters");
  end
  logic [NS-1:0] raw, filt, filt_d;
  assign raw = {bus.enc_i, bus.enc_b, bus.enc_a};
  // each raw pin: 2-FF synchronizer, then a level that moves only after FILTER_LEN equal samples
  for (genvar j = 0; j < NS; j++) begin : g_flt
    logic          s1, s2, cand, lvl;
    logic [RW-1:0] run, run_n;
    assign run_n = (s2 != cand) ? RW'(1) : (run == RW'(FILTER_LEN)) ? run : run + 1'b1;
    always_ff @(posedge sclk)
      if (!rstn) {s1, s2, cand, lvl, run} <= '0;
      else begin
        s1   <= raw[j];
        s2   <= s1;
        cand <= s2;
        run  <= run_n;
        lvl  <= (run_n == RW'(FILTER_LEN)) ? s2 : lvl;
      end
    assign filt[j] = lvl;
  end
  always_ff @(posedge sclk) filt_d <= rstn ? filt : '0;
`ifdef QENC_VELOCITY_EN
  localparam int WW = $clog2(VEL_PERIOD + 1);
  localparam logic signed [VEL_W-1:0] VMAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VMIN = {1'b1, {(VEL_W-1){1'b0}}};
  logic [WW-1:0] wcnt;
  logic          tc;
  assign tc = wcnt == WW'(VEL_PERIOD - 1);
  always_ff @(posedge sclk)
    if (!rstn) begin
      wcnt          <= '0;
      bus.vel_valid <= 1'b0;
    end else begin
      wcnt          <= tc ? '0 : wcnt + 1'b1;
      bus.vel_valid <= tc;
    end
`else
  assign bus.vel       = '0;
  assign bus.vel_valid = 1'b0;
`endif
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic               a, b, i, pa, pb, pi, step, up, ill, homing, armed, found, er;
    logic [COUNT_W-1:0] cnt;
    assign {i, b, a}    = {filt[2*NUM_CH+k], filt[NUM_CH+k], filt[k]};
    assign {pi, pb, pa} = {filt_d[2*NUM_CH+k], filt_d[NUM_CH+k], filt_d[k]};
    assign step   = (a ^ pa) ^ (b ^ pb);
    assign ill    = (a ^ pa) & (b ^ pb);
    assign up     = a ^ pb;
    assign homing = armed & i & ~pi & ~bus.home[k];
    always_ff @(posedge sclk)
      if (!rstn) {cnt, armed, found, er} <= '0;
      else begin
        cnt   <= (bus.home[k] || homing) ? '0 :
                 !step ? cnt :
                 up ? ((cnt == CMAX) ? '0 : cnt + 1'b1) :
                      ((cnt == '0) ? CMAX : cnt - 1'b1);
        armed <= homing ? 1'b0 : armed | bus.arm_index[k];
        found <= homing | (found & ~(bus.arm_index[k] & ~armed));
        er    <= ill | (er & ~bus.err_clr[k]);
      end
    assign bus.count[k*COUNT_W +: COUNT_W] = cnt;
    assign bus.index_armed[k] = armed;
    assign bus.index_found[k] = found;
    assign bus.err[k]         = er;
`ifdef QENC_VELOCITY_EN
    // a step on the terminal cycle starts the fresh window instead of the published one
    logic signed [VEL_W-1:0] acc, base, vreg;
    assign base = tc ? '0 : acc;
    always_ff @(posedge sclk)
      if (!rstn) {acc, vreg} <= '0;
      else begin
        acc  <= !step ? base :
                up ? ((base == VMAX) ? base : base + 1'b1) :
                     ((base == VMIN) ? base : base - 1'b1);
        vreg <= tc ? acc : vreg;
      end
    assign bus.vel[k*VEL_W +: VEL_W] = vreg;
`endif
  end
endmodule

// File: tb/tb_quad_enc_multi.sv
// tb_quad_enc_multi: directed plus randomized bench for quad_enc_multi against a gray-phase position model
module tb_quad_enc_multi;
  localparam int NCH = 4, CW = 13, CPR = 8192, FL = 4, VP = 1000, VW = 16, LAT = FL + 3;
  logic sclk = 1'b0, rstn = 1'b0;
  int   checks = 0, failures = 0, cyc = 0;
  bit   vv_seen = 1'b0;
  int   ph [NCH];
  int   pos [NCH];
  int   wsum [NCH][128];
  int   prev, ch, dir;

  quad_enc_multi_if #(.NUM_CH(NCH), .COUNT_W(CW), .VEL_W(VW)) bus ();
  quad_enc_multi #(.NUM_CH(NCH), .COUNTS_PER_REV(CPR), .COUNT_W(CW), .FILTER_LEN(FL),
                   .VEL_PERIOD(VP), .VEL_W(VW)) dut (.sclk(sclk), .rstn(rstn), .bus(bus));

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= rstn ? cyc + 1 : 0;
  always @(posedge sclk) if (bus.vel_valid === 1'b1) vv_seen <= 1'b1;

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int c);
    return bus.count[c*CW +: CW];
  endfunction

  // gray phase 0..3 maps to {A,B} = 00,10,11,01; +1 phase is one forward count
  task automatic drive(input int c);
    bus.enc_a[c] = (ph[c] == 1 || ph[c] == 2);
    bus.enc_b[c] = (ph[c] >= 2);
  endtask

  task automatic step(input int c, input int d);
    int w;
    ph[c]  = (ph[c] + d) & 3;
    pos[c] = (pos[c] + d + CPR) % CPR;
    w = (cyc + LAT) / VP;
    if (w < 128) wsum[c][w] += d;
    drive(c);
  endtask

  task automatic pulse_i(input int c);
    bus.enc_i[c] = 1'b1;
    tick(8);
    bus.enc_i[c] = 1'b0;
    tick(LAT + 2);
  endtask

`ifdef QENC_VELOCITY_EN
  task automatic wait_vv();
    int n = 0;
    int w;
    while (bus.vel_valid !== 1'b1 && n < 2 * VP) begin
      tick(1);
      n++;
    end
    chk("vel_valid_seen", bus.vel_valid, 1);
    w = (cyc / VP) - 1;
    if (w < 0) w = 0;
    for (int c = 0; c < NCH; c++)
      chk($sformatf("vel_ch%0d", c), $signed(bus.vel[c*VW +: VW]), wsum[c][w]);
  endtask
`endif

  initial begin
    bus.enc_a = '0; bus.enc_b = '0; bus.enc_i = '0;
    bus.home = '0; bus.arm_index = '0; bus.err_clr = '0;
    for (int c = 0; c < NCH; c++) begin
      ph[c] = 0;
      pos[c] = 0;
      for (int w = 0; w < 128; w++) wsum[c][w] = 0;
    end
    tick(4);
    for (int c = 0; c < NCH; c++) chk($sformatf("rst_count%0d", c), cnt_of(c), 0);
    chk("rst_armed", bus.index_armed, 0);
    chk("rst_found", bus.index_found, 0);
    chk("rst_err", bus.err, 0);
    for (int c = 0; c < NCH; c++) chk($sformatf("rst_vel%0d", c), bus.vel[c*VW +: VW], 0);
    chk("rst_vel_valid", bus.vel_valid, 0);
    rstn = 1'b1;
    tick(2);

    for (int e = 0; e < 32; e++) begin
      prev = pos[0];
      step(0, 1);
      tick(LAT - 1);
      chk("ch0_before_latency", cnt_of(0), prev);
      tick(1);
      chk("ch0_step", cnt_of(0), pos[0]);
      tick(10 - LAT);
    end
    chk("ch0_total", cnt_of(0), 32);
    for (int c = 1; c < NCH; c++) chk($sformatf("idle_ch%0d", c), cnt_of(c), 0);

    step(1, -1); tick(LAT);
    chk("ch1_wrap_down", cnt_of(1), CPR - 1);
    step(1, 1); tick(LAT);
    chk("ch1_wrap_up", cnt_of(1), 0);

    bus.enc_a[2] = 1'b1; tick(2); bus.enc_a[2] = 1'b0; tick(LAT + 4);
    chk("ch2_glitch_cnt", cnt_of(2), pos[2]);
    chk("ch2_glitch_err", bus.err[2], 0);
    ph[2] = (ph[2] + 2) & 3; drive(2); tick(LAT);
    chk("ch2_illegal_err", bus.err, 4'b0100);
    chk("ch2_illegal_cnt", cnt_of(2), pos[2]);
    bus.err_clr[2] = 1'b1; tick(1); bus.err_clr[2] = 1'b0;
    chk("ch2_err_clr", bus.err[2], 0);
    ph[2] = (ph[2] + 2) & 3; drive(2); tick(LAT - 1);
    bus.err_clr[2] = 1'b1; tick(1); bus.err_clr[2] = 1'b0;
    chk("ch2_set_wins", bus.err[2], 1);
    step(2, 1); tick(LAT);
    chk("ch2_step_after_err", cnt_of(2), pos[2]);

    for (int e = 0; e < 500; e++) begin step(3, 1); tick(FL + 2); end
    tick(LAT);
    chk("ch3_500", cnt_of(3), 500);
    pulse_i(3);
    chk("ch3_unarmed_idx_cnt", cnt_of(3), 500);
    chk("ch3_unarmed_idx_armed", bus.index_armed[3], 0);
    bus.arm_index[3] = 1'b1; tick(1); bus.arm_index[3] = 1'b0;
    chk("ch3_armed", bus.index_armed[3], 1);
    chk("ch3_found_before", bus.index_found[3], 0);
    bus.enc_i[3] = 1'b1; tick(LAT); pos[3] = 0;
    chk("ch3_homed_cnt", cnt_of(3), 0);
    chk("ch3_homed_armed", bus.index_armed[3], 0);
    chk("ch3_homed_found", bus.index_found[3], 1);
    bus.enc_i[3] = 1'b0; tick(LAT + 2);
    for (int e = 0; e < 3; e++) begin step(3, 1); tick(FL + 2); end
    tick(LAT);
    pulse_i(3);
    chk("ch3_second_idx_cnt", cnt_of(3), 3);
    chk("ch3_second_idx_found", bus.index_found[3], 1);
    bus.arm_index[3] = 1'b1; tick(1); bus.arm_index[3] = 1'b0;
    chk("ch3_arm_clears_found", bus.index_found[3], 0);
    bus.home[3] = 1'b1; tick(1); bus.home[3] = 1'b0; pos[3] = 0;
    chk("ch3_home_cnt", cnt_of(3), 0);
    chk("ch3_home_keeps_arm", bus.index_armed[3], 1);
    step(3, 1); bus.enc_i[3] = 1'b1; tick(LAT); pos[3] = 0;
    chk("ch3_idx_beats_step", cnt_of(3), 0);
    chk("ch3_idx_step_found", bus.index_found[3], 1);
    bus.enc_i[3] = 1'b0; tick(LAT + 2);

    step(0, 1); tick(LAT - 1);
    bus.home[0] = 1'b1; tick(1); bus.home[0] = 1'b0; pos[0] = 0;
    chk("ch0_home_beats_step", cnt_of(0), 0);

    for (int r = 0; r < 60; r++) begin
      ch  = $urandom_range(0, NCH - 1);
      dir = $urandom_range(0, 1) ? 1 : -1;
      step(ch, dir);
      tick(LAT + $urandom_range(0, 4));
      chk($sformatf("rand_ch%0d", ch), cnt_of(ch), pos[ch]);
    end

`ifdef QENC_VELOCITY_EN
    wait_vv();
    tick(1);
    chk("vel_valid_one_cycle", bus.vel_valid, 0);
    for (int e = 0; e < 40; e++) begin step(0, 1); tick(20); end
    wait_vv();
    chk("vel_up_40", $signed(bus.vel[VW-1:0]), 40);
    tick(1);
    for (int e = 0; e < 10; e++) begin step(0, -1); tick(20); end
    wait_vv();
    chk("vel_down_10", $signed(bus.vel[VW-1:0]), -10);
`else
    tick(VP + 10);
    chk("no_vel_valid", vv_seen, 0);
    for (int c = 0; c < NCH; c++) chk($sformatf("no_vel%0d", c), bus.vel[c*VW +: VW], 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/quad_enc_multi.md
Name: quad_enc_multi

Overview:
- Multi-channel 4X quadrature decoder; successor to the single-channel encoder interface on the rover motor-control FPGA.
- Per-channel features: glitch filtering, modulo position counting, index-pulse homing, illegal-transition detection, optional windowed velocity.
- Sits between the encoder input pins and the motor-control register file / PID loop.

Parameters:
- NUM_CH, 4, number of independent encoder channels
- COUNTS_PER_REV, 8192, modulo of position counter; legal count range 0..COUNTS_PER_REV-1
- COUNT_W, 13, position counter width; must satisfy 2**COUNT_W >= COUNTS_PER_REV
- FILTER_LEN, 4, consecutive stable sclk cycles required before a filtered A/B/I level updates; >= 1
- VEL_PERIOD, 100000, sclk cycles per velocity window
- VEL_W, 16, signed velocity output width

Ports:
- sclk  in  1  system clock
- rstn  in  1  reset; synchronous, active-low
- enc_a  in  NUM_CH  raw A inputs, asynchronous
- enc_b  in  NUM_CH  raw B inputs, asynchronous
- enc_i  in  NUM_CH  raw index inputs, asynchronous
- home  in  NUM_CH  per-channel synchronous clear of count
- arm_index  in  NUM_CH  1-cycle pulse; arms index capture on that channel
- err_clr  in  NUM_CH  1-cycle pulse; clears sticky error
- count  out  NUM_CH*COUNT_W  position; channel k at [k*COUNT_W +: COUNT_W]
- index_armed  out  NUM_CH  index capture pending
- index_found  out  NUM_CH  sticky; set on first index homing after arm
- err  out  NUM_CH  sticky illegal-transition flag
- vel  out  NUM_CH*VEL_W  signed counts per window; channel k at [k*VEL_W +: VEL_W]
- vel_valid  out  1  1-cycle strobe when vel updates

Behaviour:
- Reset (rstn=0 at sclk edge): count, index_armed, index_found, err, vel and vel_valid all 0. Synchronizers and filters cleared; filtered levels = 0. Window counter = 0.
- Input path per signal: 2-FF synchronizer, then stability filter. Filtered level takes the synchronized value only after FILTER_LEN consecutive identical samples. Any mismatch restarts the run.
- Latency: raw edge to count update = 2 + FILTER_LEN + 1 sclk cycles, with the input stable throughout.
- Decode uses previous/current filtered {A,B}:
  - no change: no action
  - exactly one of A/B changed: step; direction = A_cur ^ B_prev; 1 = up, 0 = down
  - both changed: illegal; err set; count unchanged; velocity unaffected
- Wrap: up at COUNTS_PER_REV-1 -> 0; down at 0 -> COUNTS_PER_REV-1. Count never equals COUNTS_PER_REV.
- Index homing: arm_index sets index_armed. While armed, a filtered I rising edge sets count to 0, clears index_armed, and sets index_found. Unarmed index edges are ignored.
- arm_index while already armed: no effect. arm_index also clears index_found.
- Priority on the same cycle, highest first: rstn, home, index homing, step. Home clears count but leaves index_armed intact. An index edge coincident with a step yields count = 0.
- err_clr clears err. Simultaneous err_clr and a new illegal transition: err stays 1 (set wins).
- Mid-operation home or err_clr does not disturb filters or synchronizers.
- All channels are fully independent, except the shared velocity window timer.

Optional Feature:
- Macro: QENC_VELOCITY_EN.
- Defined:
  - Per-channel signed accumulator, +1 per up step, -1 per down step, saturating at the VEL_W signed limits.
  - Window counter runs 0..VEL_PERIOD-1. At terminal count, all channels' accumulators are copied to vel together, vel_valid pulses for 1 cycle, and the accumulators restart.
  - A step landing on the terminal cycle counts toward the new window.
  - Home and index homing do not affect velocity.
- Not defined: no accumulators or window counter synthesized; vel tied to 0; vel_valid tied to 0.

Test Plan:
- Reset, then 8 forward quadrature cycles (32 edges) on ch0, edges spaced 10 cycles -> count[ch0] = 32; other channels = 0; each update lands 2+FILTER_LEN+1 cycles after its edge.
- Ch1 at count 0, one reverse edge -> count = 8191. From 8191, one forward edge -> 0.
- Ch2: 2-cycle glitch on A with FILTER_LEN=4 -> no count change. A and B toggled on the same cycle -> err[2] = 1 and count unchanged. err_clr coincident with another illegal transition -> err stays 1.
- Ch3 at count 500: index pulse with no arm -> count stays 500. arm_index, then index pulse -> count = 0, index_armed = 0, index_found = 1. Second index pulse -> ignored.
- home asserted on the same cycle as a forward step on ch0 -> count = 0.
- With QENC_VELOCITY_EN and VEL_PERIOD=1000: 40 up edges within one window on ch0 -> vel[ch0] = 40 with vel_valid pulse. Next window with 10 down edges -> vel[ch0] = -10. Without the macro -> vel = 0 and vel_valid never asserts.
